// File: rtl/enhance_stream_out_ctrl_if.sv
// -----------------------------------------------------------------------------
// enhance_stream_out_ctrl_if
//
// Purpose: AXI4-Stream bundle carrying packed enhance pixels toward the DMA.
//
// Signals:
//   tvalid  word available
//   tready  sink can take the word
//   tdata   four packed 8-bit pixels, first pixel in [7:0]
//   tuser   word holds pixel 0 of a frame
//   tlast   word holds the last pixel of a frame (or of a line when
//           LINE_TLAST_EN is defined in the controller build)
//
// Modports:
//   master  drives tvalid/tdata/tuser/tlast, samples tready
//   slave   samples tvalid/tdata/tuser/tlast, drives tready
// -----------------------------------------------------------------------------
interface enhance_stream_out_ctrl_if;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;
  logic        tuser;
  logic        tlast;

  modport master (
    output tvalid,
    output tdata,
    output tuser,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tuser,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/enhance_stream_out_ctrl.sv
// -----------------------------------------------------------------------------
// enhance_stream_out_ctrl
//
// Purpose: sink end of the enhance pixel stream. Packs four 8-bit pixels per
// 32-bit word, buffers words in a first-word-fall-through FIFO and presents
// them on an AXI4-Stream master. tuser marks the first word of a frame, tlast
// the last one. The pixel input has no backpressure, so a word that finds
// the FIFO full is dropped, overflow is raised (sticky) and the remainder of
// the frame is thrown away so the next frame starts cleanly.
//
// Optional build macro: LINE_TLAST_EN
//   defined   - tlast on the last word of every line, and the discard window
//               after an overflow ends at the end of the current line
//   undefined - tlast on the last word of the frame only
//
// Ports:
//   s_axi_aclk     clock
//   s_axi_aresetn  synchronous active-low reset
//   enhance_valid  input pixel strobe
//   enhance_dout   input pixel
//   m_axis         AXI4-Stream master (tvalid/tready/tdata/tuser/tlast)
//   overflow       sticky, a word was dropped since reset
//   frame_done     one-cycle pulse after the last pixel of a frame
//
// States:
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   ST_STREAM  | completed words are pushed into the FIFO
//   ST_DISCARD | an overflow hit mid-segment; pixels are counted but no word
//              | is pushed until the segment (frame or line) ends
// -----------------------------------------------------------------------------
module enhance_stream_out_ctrl #(
  parameter int IMG_WIDTH  = 128,
  parameter int IMG_HEIGHT = 128,
  parameter int FIFO_AW    = 4
) (
  input  logic                             s_axi_aclk,
  input  logic                             s_axi_aresetn,
  input  logic                             enhance_valid,
  input  logic [7:0]                       enhance_dout,
  enhance_stream_out_ctrl_if.master        m_axis,
  output logic                             overflow,
  output logic                             frame_done
);

  localparam int FRAME_PIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int PIX_W     = (FRAME_PIX > 4) ? $clog2(FRAME_PIX) : 2;
  localparam int DEPTH     = 1 << FIFO_AW;

  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(FRAME_PIX - 1);
  localparam logic [FIFO_AW:0] CNT_FULL = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic {
    ST_STREAM  = 1'b0,
    ST_DISCARD = 1'b1
  } state_t;

  state_t             state;
  logic [PIX_W-1:0]   pix_cnt;
  logic [1:0]         lane;
  logic               frame_end;
  logic               seg_end;

  // Lanes 0..2 of the word being assembled; lane 3 completes it directly.
  logic [23:0]        word_acc;

  // Completed word, held for the push on the following cycle.
  logic               word_pend;
  logic [31:0]        word_data;
  logic               word_user;
  logic               word_last;

  logic [33:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   fifo_cnt;
  logic               fifo_empty;
  logic               fifo_pop;
  logic               push_ok;
  logic [33:0]        rd_word;

  assign lane      = pix_cnt[1:0];
  assign frame_end = (pix_cnt == PIX_LAST);

`ifdef LINE_TLAST_EN
  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);

  logic [COL_W-1:0] col_cnt;

  // Column position kept as its own counter to avoid a modulo on pix_cnt.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      col_cnt <= '0;
    end else if (enhance_valid) begin
      col_cnt <= (col_cnt == COL_LAST) ? '0 : col_cnt + 1'b1;
    end
  end

  assign seg_end = (col_cnt == COL_LAST);
`else
  assign seg_end = frame_end;
`endif

  // ---------------------------------------------------------------------------
  // FIFO status and handshake
  // ---------------------------------------------------------------------------
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_pop   = !fifo_empty && m_axis.tready;

  // A full FIFO still takes the word when the head leaves in the same cycle.
  assign push_ok    = word_pend && ((fifo_cnt != CNT_FULL) || fifo_pop);

  assign rd_word    = mem[rd_ptr];

  // Outputs are forced to zero while empty so reset leaves tdata at 0 even
  // though the storage array itself is not reset.
  assign m_axis.tvalid = !fifo_empty;
  assign m_axis.tdata  = fifo_empty ? 32'h0 : rd_word[31:0];
  assign m_axis.tuser  = fifo_empty ? 1'b0  : rd_word[32];
  assign m_axis.tlast  = fifo_empty ? 1'b0  : rd_word[33];

  // ---------------------------------------------------------------------------
  // Pixel counting, word packing and overflow state machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      state      <= ST_STREAM;
      pix_cnt    <= '0;
      word_acc   <= '0;
      word_pend  <= 1'b0;
      word_data  <= '0;
      word_user  <= 1'b0;
      word_last  <= 1'b0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= enhance_valid && frame_end;
      word_pend  <= 1'b0;

      // Rejected push. Losing the segment's last word needs no discard
      // window because the next word already starts a fresh segment.
      if (word_pend && !push_ok) begin
        overflow <= 1'b1;
        if (!word_last) begin
          state <= ST_DISCARD;
        end
      end

      if (enhance_valid) begin
        pix_cnt <= frame_end ? '0 : pix_cnt + 1'b1;

        case (lane)
          2'd0: word_acc[7:0]   <= enhance_dout;
          2'd1: word_acc[15:8]  <= enhance_dout;
          2'd2: word_acc[23:16] <= enhance_dout;
          default: begin
            word_data <= {enhance_dout, word_acc};
            word_user <= (pix_cnt[PIX_W-1:2] == '0);
            word_last <= seg_end;
            word_pend <= (state == ST_STREAM);
          end
        endcase

        // A drop and a segment end are always at least three pixels apart,
        // so this never competes with the transition into ST_DISCARD above.
        if (seg_end && (state == ST_DISCARD)) begin
          state <= ST_STREAM;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_aresetn && push_ok) begin
      mem[wr_ptr] <= {word_last, word_user, word_data};
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_enhance_stream_out_ctrl.sv
// -----------------------------------------------------------------------------
// tb_enhance_stream_out_ctrl
//
// Purpose: self-checking bench for enhance_stream_out_ctrl. A transaction-level
// reference model (pixel index arithmetic plus a queue standing in for the
// FIFO) predicts every output each cycle; directed phases cover latency,
// reset mid-frame, a clean frame, a fully stalled frame and a random phase.
// -----------------------------------------------------------------------------
module tb_enhance_stream_out_ctrl;

  localparam int W     = 128;
  localparam int H     = 128;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int FRAME = W * H;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h0;
  logic       overflow;
  logic       frame_done;

  always #5 clk = ~clk;

  enhance_stream_out_ctrl_if axis_if ();

  enhance_stream_out_ctrl #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .FIFO_AW    (AW)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .enhance_valid (in_valid),
    .enhance_dout  (in_data),
    .m_axis        (axis_if),
    .overflow      (overflow),
    .frame_done    (frame_done)
  );

  int n_chk = 0;
  int n_err = 0;

  int beats;
  int user_beats;
  int last_beats;
  int fd_cnt;

  // Reference model state
  int          pix_m;
  logic [23:0] acc_m;
  bit          pend_v;
  logic [33:0] pend_w;
  logic [33:0] q[$];
  bit          ovf_m;
  bit          fd_m;
  bit          disc_m;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pix_m  = 0;
    acc_m  = '0;
    pend_v = 1'b0;
    pend_w = '0;
    q.delete();
    ovf_m  = 1'b0;
    fd_m   = 1'b0;
    disc_m = 1'b0;
  endtask

  task automatic clear_tally();
    beats      = 0;
    user_beats = 0;
    last_beats = 0;
    fd_cnt     = 0;
  endtask

  // One clock cycle: check outputs against the model, drive the inputs for
  // this cycle, then advance the model across the coming rising edge.
  task automatic step(input bit v, input logic [7:0] d, input bit rdy);
    bit          pop;
    bit          disc0;
    bit          seg_end;
    int          sz;
    int          lane;
    logic [33:0] hd;

    @(negedge clk);
    chk("tvalid", 64'(axis_if.tvalid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      hd = q[0];
      chk("tdata", 64'(axis_if.tdata), 64'(hd[31:0]));
      chk("tuser", 64'(axis_if.tuser), 64'(hd[32]));
      chk("tlast", 64'(axis_if.tlast), 64'(hd[33]));
    end
    chk("overflow", 64'(overflow), 64'(ovf_m));
    chk("frame_done", 64'(frame_done), 64'(fd_m));

    in_valid       = v;
    in_data        = d;
    axis_if.tready = rdy;

    if (axis_if.tvalid && rdy) begin
      beats++;
      if (axis_if.tuser) user_beats++;
      if (axis_if.tlast) last_beats++;
    end
    if (frame_done) fd_cnt++;

    sz    = q.size();
    pop   = (sz != 0) && rdy;
    disc0 = disc_m;
    if (pop) q.delete(0);
    if (pend_v) begin
      if (sz < DEPTH || pop) begin
        q.push_back(pend_w);
      end else begin
        ovf_m = 1'b1;
        if (!pend_w[33]) disc_m = 1'b1;
      end
    end

    pend_v = 1'b0;
    fd_m   = 1'b0;
    if (v) begin
      lane = pix_m % 4;
`ifdef LINE_TLAST_EN
      seg_end = ((pix_m % W) == W - 1);
`else
      seg_end = (pix_m == FRAME - 1);
`endif
      if (lane == 3) begin
        if (!disc0) begin
          pend_v = 1'b1;
          pend_w = {seg_end, ((pix_m / 4) == 0), d, acc_m};
        end
      end else begin
        acc_m[8*lane +: 8] = d;
      end
      if (seg_end) disc_m = 1'b0;
      fd_m  = (pix_m == FRAME - 1);
      pix_m = (pix_m + 1) % FRAME;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    in_valid       = 1'b0;
    in_data        = 8'h0;
    axis_if.tready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_tvalid", 64'(axis_if.tvalid), 64'(0));
    chk("rst_tdata", 64'(axis_if.tdata), 64'(0));
    chk("rst_tuser", 64'(axis_if.tuser), 64'(0));
    chk("rst_tlast", 64'(axis_if.tlast), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    chk("rst_frame_done", 64'(frame_done), 64'(0));
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    axis_if.tready = 1'b0;
    model_reset();
    clear_tally();

    // Latency: pixels at cycles 10..13 -> tvalid exactly two cycles later.
    do_reset();
    repeat (10) step(1'b0, 8'h0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(i), 1'b1);
    step(1'b0, 8'h0, 1'b1);
    chk("lat_n1_tvalid", 64'(axis_if.tvalid), 64'(0));
    step(1'b0, 8'h0, 1'b1);
    chk("lat_n2_tvalid", 64'(axis_if.tvalid), 64'(1));
    chk("lat_word", 64'(axis_if.tdata), 64'(32'h03020100));
    chk("lat_tuser", 64'(axis_if.tuser), 64'(1));
    step(1'b0, 8'h0, 1'b1);
    chk("lat_one_beat", 64'(axis_if.tvalid), 64'(0));

    // Reset after pixel 6 of a frame, then a clean ramp frame.
    step(1'b1, 8'h04, 1'b1);
    step(1'b1, 8'h05, 1'b1);
    do_reset();
    clear_tally();
    for (int i = 0; i < FRAME; i++) step(1'b1, 8'(i), 1'b1);
    repeat (4) step(1'b0, 8'h0, 1'b1);
    chk("ramp_beats", 64'(beats), 64'(FRAME / 4));
    chk("ramp_tuser_beats", 64'(user_beats), 64'(1));
    chk("ramp_tlast_beats", 64'(last_beats), 64'(1));
    chk("ramp_frame_done", 64'(fd_cnt), 64'(1));
    chk("ramp_overflow", 64'(overflow), 64'(0));

    // Fully stalled frame: 16 words held, the rest of the frame discarded.
    clear_tally();
    for (int i = 0; i < FRAME; i++) step(1'b1, 8'($urandom), 1'b0);
    chk("stall_beats", 64'(beats), 64'(0));
    chk("stall_overflow", 64'(overflow), 64'(1));
    clear_tally();
    repeat (24) step(1'b0, 8'h0, 1'b1);
    chk("drain_beats", 64'(beats), 64'(DEPTH));
    chk("drain_tlast_beats", 64'(last_beats), 64'(0));

    // Next frame after the overflow is complete.
    clear_tally();
    for (int i = 0; i < FRAME; i++) step(1'b1, 8'($urandom), 1'b1);
    repeat (4) step(1'b0, 8'h0, 1'b1);
    chk("post_beats", 64'(beats), 64'(FRAME / 4));
    chk("post_tuser_beats", 64'(user_beats), 64'(1));
    chk("post_tlast_beats", 64'(last_beats), 64'(1));
    chk("post_overflow_sticky", 64'(overflow), 64'(1));

    // Random phase from a fresh reset: sparse pixels, mostly stalled sink so
    // the FIFO sits at full and sees same-cycle push/pop.
    do_reset();
    for (int i = 0; i < 12000; i++) begin
      step(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 4) == 0));
    end
    repeat (40) step(1'b0, 8'h0, 1'b1);
    chk("rand_drained", 64'(axis_if.tvalid), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
